// File: rtl/resp_arb_pkg.sv
// Shared types and helpers for the BLE response transmit arbiter.
package resp_arb_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} arb_st_t;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  // Wide enough for up to 8 requesters.
  localparam int unsigned PTR_W = 3;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr, input int unsigned n);
    if (32'(ptr) + 32'd1 >= n) return '0;
    return ptr + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending index at or after rr_ptr, wrapping.
module rr_pick
  import resp_arb_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]  pend,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  logic             hi_any, lo_any;
  logic [PTR_W-1:0] hi_idx, lo_idx;

  // Scan downwards so the lowest index in each half is the last one written.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        if (PTR_W'(i) >= rr_ptr) begin
          hi_any = 1'b1;
          hi_idx = PTR_W'(i);
        end else begin
          lo_any = 1'b1;
          lo_idx = PTR_W'(i);
        end
      end
    end
  end

  assign any     = hi_any | lo_any;
  assign gnt_idx = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/resp_tx_arb.sv
// Round-robin sharing of one UART transmitter among NREQ single-byte requesters.
// Optional macro RESP_PRIO0_EN gives requester 0 strict priority.
module resp_tx_arb
  import resp_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned TX_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_byte,
  input  logic              tx_done,
  output logic              trmt,
  output logic [7:0]        tx_data,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [NREQ-1:0]   ovfl,
  input  logic              clr_ovfl
);

  arb_st_t          state_q, state_d;
  logic [NREQ-1:0]  pend_q, pend_d;
  logic [7:0]       byte_q [NREQ];
  logic [7:0]       byte_d [NREQ];
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gnt_q, gnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             trmt_q, trmt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [NREQ-1:0]  ovfl_q, ovfl_d;
  logic [NREQ-1:0]  load_hit;
  logic [PTR_W-1:0] pick_idx, win_idx;
  logic             pick_any;

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .pend   (pend_q),
    .rr_ptr (rr_ptr_q),
    .gnt_idx(pick_idx),
    .any    (pick_any)
  );

`ifdef RESP_PRIO0_EN
  assign win_idx = pend_q[0] ? '0 : pick_idx;
`else
  assign win_idx = pick_idx;
`endif

  // The slot being drained this cycle may be refilled without counting as an overflow.
  assign load_hit = (state_q == LOAD) ? (NREQ'(1) << gnt_q) : '0;

  always_comb begin
    pend_d = pend_q;
    byte_d = byte_q;
    ovfl_d = clr_ovfl ? '0 : ovfl_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (load_hit[i]) pend_d[i] = 1'b0;
      if (req[i]) begin
        if (!pend_q[i] || load_hit[i]) begin
          byte_d[i] = req_byte[8*i +: 8];
          pend_d[i] = 1'b1;
        end else begin
          ovfl_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gap_d     = gap_q;
    rr_ptr_d  = rr_ptr_q;
    tx_data_d = tx_data_q;
    trmt_d    = 1'b0;
    done_d    = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = win_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = byte_q[gnt_q];
        trmt_d    = 1'b1;
`ifdef RESP_PRIO0_EN
        rr_ptr_d  = (gnt_q == '0) ? rr_ptr_q : ptr_inc(gnt_q, NREQ);
`else
        rr_ptr_d  = ptr_inc(gnt_q, NREQ);
`endif
        state_d   = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          done_d  = NREQ'(1) << gnt_q;
          gap_d   = '0;
          state_d = (TX_GAP == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (32'(gap_q) + 32'd1 >= TX_GAP) state_d = IDLE;
        else gap_d = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      byte_q    <= '{default: '0};
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      gap_q     <= '0;
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
      done_q    <= '0;
      ovfl_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      byte_q    <= byte_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      gap_q     <= gap_d;
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      ovfl_q    <= ovfl_d;
    end
  end

  assign trmt    = trmt_q;
  assign tx_data = tx_data_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign ovfl    = ovfl_q;

endmodule

// File: tb/tb_resp_tx_arb.sv
// Scoreboard bench for resp_tx_arb: expected bytes queued at request time, checked at trmt.
module tb_resp_tx_arb;

  localparam int unsigned NREQ = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_byte;
  logic              tx_done;
  logic              trmt;
  logic [7:0]        tx_data;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [NREQ-1:0]   ovfl;
  logic              clr_ovfl;

  typedef struct {
    int         idx;
    logic [7:0] b;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cur_idx = 0;

  resp_tx_arb #(
    .NREQ  (NREQ),
    .TX_GAP(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_byte(req_byte),
    .tx_done (tx_done),
    .trmt    (trmt),
    .tx_data (tx_data),
    .done    (done),
    .busy    (busy),
    .ovfl    (ovfl),
    .clr_ovfl(clr_ovfl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_byte = '0;
    tx_done  = 1'b0;
    clr_ovfl = 1'b0;
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input int idx, input logic [7:0] b, input bit expect_sent);
    req[idx]             = 1'b1;
    req_byte[8*idx +: 8] = b;
    if (expect_sent) begin
      exp_t e;
      e.idx = idx;
      e.b   = b;
      sb_q.push_back(e);
    end
  endtask

  task automatic push_exp(input int idx, input logic [7:0] b);
    exp_t e;
    e.idx = idx;
    e.b   = b;
    sb_q.push_back(e);
  endtask

  task automatic check_tx(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_byte"}, 32'(tx_data), 32'(e.b));
    cur_idx = e.idx;
  endtask

  task automatic wait_trmt(input string tag, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!trmt && lat < 100);
    if (!trmt) check({tag, "_trmt_timeout"}, 32'(trmt), 32'd1);
    else check_tx(tag);
  endtask

  task automatic finish_byte(input string tag, input int hold);
    repeat (hold) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1 << cur_idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;

    // Reset state
    do_reset();
    check("rst_trmt", 32'(trmt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovfl", 32'(ovfl), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'h00);

    // 1: single command response, latency and gap timing
    drive_req(0, 8'hA5, 1'b1);
    tick();
    req = '0;
    check("t1_trmt_t1", 32'(trmt), 32'd0);
    tick();
    check("t1_trmt_t2", 32'(trmt), 32'd0);
    tick();
    check("t1_trmt_t3", 32'(trmt), 32'd1);
    check_tx("t1");
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_trmt_pulse", 32'(trmt), 32'd0);
    finish_byte("t1", 19);
    check("t1_busy_gap1", 32'(busy), 32'd1);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_busy_gap2", 32'(busy), 32'd1);
    tick();
    check("t1_busy_fall", 32'(busy), 32'd0);

    // 2: three simultaneous requests, round-robin order and spacing
    do_reset();
    drive_req(0, 8'hA5, 1'b1);
    drive_req(1, 8'h11, 1'b1);
    drive_req(2, 8'h22, 1'b1);
    tick();
    req = '0;
    wait_trmt("t2a", lat);
    check("t2a_lat", 32'(lat), 32'd2);
    finish_byte("t2a", 5);
    wait_trmt("t2b", lat);
    check("t2b_gap", 32'(lat), 32'd4);
    finish_byte("t2b", 3);
    wait_trmt("t2c", lat);
    check("t2c_gap", 32'(lat), 32'd4);
    finish_byte("t2c", 2);

    // 3: overflow on a full slot, clear, and clear colliding with a new overflow
    do_reset();
    drive_req(1, 8'h33, 1'b1);
    tick();
    drive_req(1, 8'h44, 1'b0);
    tick();
    req = '0;
    check("t3_ovfl_set", 32'(ovfl), 32'b010);
    wait_trmt("t3", lat);
    finish_byte("t3", 4);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (trmt) cnt++;
    end
    check("t3_dropped_not_sent", 32'(cnt), 32'd0);
    check("t3_ovfl_sticky", 32'(ovfl), 32'b010);
    clr_ovfl = 1'b1;
    tick();
    clr_ovfl = 1'b0;
    check("t3_ovfl_clr", 32'(ovfl), 32'd0);
    drive_req(1, 8'h55, 1'b1);
    tick();
    drive_req(1, 8'h66, 1'b0);
    clr_ovfl = 1'b1;
    tick();
    req      = '0;
    clr_ovfl = 1'b0;
    check("t3_ovfl_wins_clr", 32'(ovfl), 32'b010);
    wait_trmt("t3b", lat);
    finish_byte("t3b", 2);

    // 4: requester 0 arriving during WAIT with 1 and 2 pending
    do_reset();
    drive_req(0, 8'h10, 1'b1);
    tick();
    req = '0;
    wait_trmt("t4a", lat);
    drive_req(1, 8'h21, 1'b0);
    drive_req(2, 8'h32, 1'b0);
    tick();
    req = '0;
    tick();
    drive_req(0, 8'h40, 1'b0);
    tick();
    req = '0;
`ifdef RESP_PRIO0_EN
    push_exp(0, 8'h40);
    push_exp(1, 8'h21);
    push_exp(2, 8'h32);
`else
    push_exp(1, 8'h21);
    push_exp(2, 8'h32);
    push_exp(0, 8'h40);
`endif
    finish_byte("t4a", 2);
    wait_trmt("t4b", lat);
    finish_byte("t4b", 2);
    wait_trmt("t4c", lat);
    finish_byte("t4c", 2);
    wait_trmt("t4d", lat);
    finish_byte("t4d", 2);
    check("t4_ovfl", 32'(ovfl), 32'd0);

    // 5: reset during WAIT abandons the byte and empties all slots
    do_reset();
    drive_req(1, 8'h77, 1'b1);
    tick();
    req = '0;
    wait_trmt("t5", lat);
    drive_req(2, 8'h88, 1'b0);
    tick();
    req     = '0;
    rst_n   = 1'b0;
    tx_done = 1'b1;
    tick();
    check("t5_rst_trmt", 32'(trmt), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_txdata", 32'(tx_data), 32'h00);
    rst_n   = 1'b1;
    tx_done = 1'b0;
    tick();
    check("t5_no_late_done", 32'(done), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t5_stray_done", 32'(done), 32'd0);
    check("t5_stray_busy", 32'(busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (trmt || busy) cnt++;
    end
    check("t5_slots_empty", 32'(cnt), 32'd0);

    // 6: refill in the LOAD cycle of the slot's own grant
    do_reset();
    drive_req(2, 8'h61, 1'b1);
    tick();
    req = '0;
    check("t6_trmt_c1", 32'(trmt), 32'd0);
    tick();
    drive_req(2, 8'h62, 1'b1);
    check("t6_trmt_c2", 32'(trmt), 32'd0);
    tick();
    req = '0;
    check("t6_trmt_c3", 32'(trmt), 32'd1);
    check_tx("t6a");
    finish_byte("t6a", 3);
    wait_trmt("t6b", lat);
    check("t6b_gap", 32'(lat), 32'd4);
    finish_byte("t6b", 2);
    check("t6_ovfl", 32'(ovfl), 32'd0);
    check("t6_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
